// File: rtl/servo_pwm_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_gen_if
// Description : Width-command write port for the four-channel servo pulse
//               generator. The command source drives the strobe, channel and
//               width; the generator reports whether it can take the write.
// Revision    : 1.0 - initial release
// ============================================================================
interface servo_pwm_gen_if;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [11:0] wr_us;
  logic        wr_ready;

  modport master (output wr_en, output wr_ch, output wr_us, input wr_ready);
  modport slave  (input wr_en, input wr_ch, input wr_us, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_gen
// Description : Four-channel RC servo pulse generator. Widths (us) are written
//               into shadow registers, copied to the active set at each frame
//               boundary, and forced to safe values when the command source
//               stops writing for FAILSAFE_FRAMES boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_gen #(
  parameter int TICKS_PER_US    = 50,
  parameter int FRAME_US        = 20000,
  parameter int MIN_US          = 1000,
  parameter int MAX_US          = 2000,
  parameter int NEUTRAL_US      = 1500,
  parameter int FAILSAFE_FRAMES = 25
) (
  input  wire logic        CLOCK_50,
  input  wire logic        Clear,
  servo_pwm_gen_if.slave   wr,
  output logic [3:0]       pwm_out,
  output logic             frame_start,
  output logic             failsafe
);

  localparam int c_tick_w = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int c_us_w   = $clog2(FRAME_US);
  localparam int c_idle_w = $clog2(FAILSAFE_FRAMES + 1);
  localparam int c_cmp_w  = (c_us_w > 12) ? c_us_w : 12;

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICKS_PER_US - 1);
  localparam logic [c_us_w-1:0]   c_us_last   = c_us_w'(FRAME_US - 1);
  localparam logic [c_idle_w-1:0] c_idle_trip = c_idle_w'(FAILSAFE_FRAMES - 1);
  localparam logic [c_idle_w-1:0] c_idle_max  = c_idle_w'(FAILSAFE_FRAMES);
  localparam logic [11:0]         c_min_us    = 12'(MIN_US);
  localparam logic [11:0]         c_max_us    = 12'(MAX_US);
  localparam logic [11:0]         c_neu_us    = 12'(NEUTRAL_US);
  // Throttle (ch3) goes to minimum so the motor is off; surfaces centre.
  localparam logic [11:0]         c_safe_us [4] = '{c_neu_us, c_neu_us, c_neu_us, c_min_us};

  logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
  logic [c_us_w-1:0]   us_cnt_q, us_cnt_d;
  logic [c_idle_w-1:0] idle_q, idle_d;
  logic                wrote_q, wrote_d;
  logic                failsafe_q, failsafe_d;
  logic [11:0]         shadow_q [4];
  logic [11:0]         shadow_d [4];
  logic [11:0]         active_q [4];
  logic [11:0]         active_d [4];
  logic [3:0]          pwm_out_q, pwm_out_d;

  logic                us_tick;
  logic                boundary;
  logic [11:0]         wr_us_clamped;

  assign us_tick     = (tick_cnt_q == c_tick_last);
  assign boundary    = us_tick && (us_cnt_q == c_us_last);
  assign frame_start = boundary;
  // Writes are refused on the boundary cycle so the shadow-to-active copy
  // never races with a shadow update.
  assign wr.wr_ready = ~boundary;
  assign pwm_out     = pwm_out_q;
  assign failsafe    = failsafe_q;

  // Next-state: timebase, shadow writes, boundary load and watchdog.
  always_comb begin
    tick_cnt_d    = us_tick ? '0 : tick_cnt_q + 1'b1;
    us_cnt_d      = us_cnt_q;
    idle_d        = idle_q;
    wrote_d       = wrote_q;
    failsafe_d    = failsafe_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    pwm_out_d     = '0;
    wr_us_clamped = wr.wr_us;

    if (wr.wr_us < c_min_us) begin
      wr_us_clamped = c_min_us;
    end else if (wr.wr_us > c_max_us) begin
      wr_us_clamped = c_max_us;
    end

    if (us_tick) begin
      us_cnt_d = (us_cnt_q == c_us_last) ? '0 : us_cnt_q + 1'b1;
    end

    if (boundary) begin
      wrote_d = 1'b0;
      if (wrote_q) begin
        idle_d     = '0;
        failsafe_d = 1'b0;
        active_d   = shadow_q;
      end else if (idle_q >= c_idle_trip) begin
        // idle saturates, so every later silent boundary reloads safe widths.
        idle_d     = c_idle_max;
        failsafe_d = 1'b1;
        active_d   = c_safe_us;
        shadow_d   = c_safe_us;
      end else begin
        idle_d   = idle_q + 1'b1;
        active_d = shadow_q;
      end
    end else if (wr.wr_en) begin
      shadow_d[wr.wr_ch] = wr_us_clamped;
      wrote_d            = 1'b1;
    end

    // Compare against the post-update counter and widths so the pulse rises
    // the cycle after frame_start and lasts active*TICKS_PER_US cycles.
    for (int i = 0; i < 4; i++) begin
      pwm_out_d[i] = (c_cmp_w'(us_cnt_d) < c_cmp_w'(active_d[i]));
    end
  end

  // State registers; Clear drops the pulses immediately.
  always_ff @(posedge CLOCK_50 or posedge Clear) begin
    if (Clear) begin
      tick_cnt_q <= '0;
      us_cnt_q   <= '0;
      idle_q     <= '0;
      wrote_q    <= 1'b0;
      failsafe_q <= 1'b0;
      shadow_q   <= c_safe_us;
      active_q   <= c_safe_us;
      pwm_out_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      us_cnt_q   <= us_cnt_d;
      idle_q     <= idle_d;
      wrote_q    <= wrote_d;
      failsafe_q <= failsafe_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pwm_out_q  <= pwm_out_d;
    end
  end

endmodule
`default_nettype wire
